// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: merges hazard stalls, branch flushes and cache-miss refills into per-stage enables/flushes
// and arbitrates the off-chip memory port between I-cache and D-cache refills, with saturating perf counters.
module pipeline_stall_ctrl #(
  parameter int FILL_CYCLES = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             br_taken,
  input  logic             ic_miss,
  input  logic             dc_miss,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int FW = FILL_CYCLES > 1 ? $clog2(FILL_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, REQ, FILL, DONE} state_t;
  state_t state_q, state_d;
  logic mem_sel_q, mem_sel_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, mem_req_c, br_flush;
  always_comb begin
    state_d = state_q;
    mem_sel_d = mem_sel_q;
    fill_d = fill_q;
    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
    {ifid_flush_c, idex_flush_c} = '0;
    mem_req_c = 1'b0;
    br_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (dc_miss || ic_miss) begin
          // the D-side miss belongs to the older instruction, so it wins the port
          state_d = REQ;
          mem_sel_d = dc_miss;
        end else if (br_taken) begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
          {ifid_flush_c, idex_flush_c} = '1;
          br_flush = 1'b1;
        end else if (hz_stall) begin
          {idex_en_c, exmem_en_c, memwb_en_c, idex_flush_c} = '1;
        end else begin
          {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '1;
        end
      end
      REQ: begin
        mem_req_c = 1'b1;
        state_d = mem_ack ? FILL : REQ;
        fill_d = mem_ack ? FW'(FILL_CYCLES - 1) : fill_q;
      end
      FILL: begin
        state_d = fill_q == '0 ? DONE : FILL;
        fill_d = fill_q == '0 ? fill_q : fill_q - FW'(1);
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      mem_sel_q <= 1'b0;
      fill_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mem_sel_q <= mem_sel_d;
      fill_q <= fill_d;
      if (!pc_en_c && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_flush && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
  assign pc_en = pc_en_c && !rst;
  assign ifid_en = ifid_en_c && !rst;
  assign idex_en = idex_en_c && !rst;
  assign exmem_en = exmem_en_c && !rst;
  assign memwb_en = memwb_en_c && !rst;
  assign ifid_flush = ifid_flush_c || rst;
  assign idex_flush = idex_flush_c || rst;
  assign mem_req = mem_req_c && !rst;
  assign busy = state_q != RUN && !rst;
  assign mem_sel = mem_sel_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed-step bench for pipeline_stall_ctrl, with a CNT_W=4 twin for saturation.
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic hz_stall = 1'b0, br_taken = 1'b0, ic_miss = 1'b0, dc_miss = 1'b0, mem_ack = 1'b0;
  logic mem_req, mem_sel, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, busy;
  logic [15:0] stall_cnt, flush_cnt;
  logic mem_req4, mem_sel4, pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4, memwb_en4, busy4;
  logic [3:0] stall_cnt4, flush_cnt4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  pipeline_stall_ctrl #(.FILL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken(br_taken), .ic_miss(ic_miss),
    .dc_miss(dc_miss), .mem_ack(mem_ack), .mem_req(mem_req), .mem_sel(mem_sel), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  pipeline_stall_ctrl #(.FILL_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hz_stall(hz_stall), .br_taken(br_taken), .ic_miss(ic_miss),
    .dc_miss(dc_miss), .mem_ack(mem_ack), .mem_req(mem_req4), .mem_sel(mem_sel4), .pc_en(pc_en4),
    .ifid_en(ifid_en4), .ifid_flush(ifid_flush4), .idex_en(idex_en4), .idex_flush(idex_flush4),
    .exmem_en(exmem_en4), .memwb_en(memwb_en4), .busy(busy4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    step();
    chk("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
    chk("rst_flush", {ifid_flush, idex_flush}, 2'b11);
    chk("rst_req_busy", {mem_req, busy}, 2'b00);
    step();
    rst = 1'b0;
    #1;
    chk("run_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 7'b1111100);
    chk("run_cnt", {stall_cnt, flush_cnt}, 32'h0);
    hz_stall = 1'b1;
    #1;
    chk("hz_out", {pc_en, ifid_en, idex_en, idex_flush, exmem_en, memwb_en, ifid_flush}, 7'b0011110);
    step();
    hz_stall = 1'b0;
    chk("hz_cnt", {stall_cnt, flush_cnt}, {16'd1, 16'd0});
    br_taken = 1'b1;
    hz_stall = 1'b1;
    #1;
    chk("br_out", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}, 7'b1111111);
    step();
    br_taken = 1'b0;
    hz_stall = 1'b0;
    chk("br_cnt", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
    dc_miss = 1'b1;
    ic_miss = 1'b1;
    #1;
    chk("miss_freeze", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_req}, 8'h00);
    step();
    chk("req_sel_d", {mem_sel, busy}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("req_hi%0d", i), {mem_req, pc_en, memwb_en}, 3'b100);
      if (i == 3) mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d", i), {mem_req, busy, pc_en, mem_sel}, 4'b0101);
      step();
    end
    chk("done", {mem_req, busy, pc_en}, 3'b010);
    dc_miss = 1'b0;
    step();
    chk("rerun_ic", {busy, pc_en, mem_req, mem_sel}, 4'b0001);
    step();
    ic_miss = 1'b0;
    chk("req_ic", {mem_req, mem_sel, busy}, 3'b101);
    chk("stall_cnt_miss", stall_cnt, 16'd12);
    chk("flush_cnt_miss", flush_cnt, 16'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("fill_ic1", {mem_req, busy}, 2'b01);
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_req, busy}, 9'b000001100);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    #1;
    chk("post_rst", {busy, mem_req, pc_en, mem_sel}, 4'b0010);
    chk("post_rst_cnt", {stall_cnt, flush_cnt}, 32'h0);
    step();
    mem_ack = 1'b0;
    chk("spurious_ack", {busy, mem_req, pc_en}, 3'b001);
    chk("spurious_cnt", stall_cnt, 16'd0);
    hz_stall = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("sat4_at15", stall_cnt4, 4'd15);
    for (int i = 0; i < 5; i++) step();
    hz_stall = 1'b0;
    chk("sat4_hold", stall_cnt4, 4'd15);
    chk("cnt16_20", stall_cnt, 16'd20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
